// File: rtl/sram_sp_port_ctrl_pkg.sv
// sram_sp_port_ctrl_pkg: shared grant encodings and default memory geometry
package sram_sp_port_ctrl_pkg;
  localparam int ADR_WD_DEF = 10;
  localparam int DAT_WD_DEF = 32;
  localparam int RSP_DEPTH_DEF = 2;
  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_WR   = 2'd1,
    GNT_RD   = 2'd2
  } gnt_e;
endpackage

// File: rtl/sram_sp_port_ctrl_if.sv
// sram_sp_port_ctrl_if: engine-side write, read and response channels
interface sram_sp_port_ctrl_if import sram_sp_port_ctrl_pkg::*; #(
  parameter int ADR_WD = ADR_WD_DEF,
  parameter int DAT_WD = DAT_WD_DEF
) ();
  logic              wr_val_i;
  logic              wr_rdy_o;
  logic [ADR_WD-1:0] wr_adr_i;
  logic [DAT_WD-1:0] wr_dat_i;
  logic              rd_val_i;
  logic              rd_rdy_o;
  logic [ADR_WD-1:0] rd_adr_i;
  logic              rsp_val_o;
  logic              rsp_rdy_i;
  logic [DAT_WD-1:0] rsp_dat_o;
  modport master (
    output wr_val_i, wr_adr_i, wr_dat_i, rd_val_i, rd_adr_i, rsp_rdy_i,
    input  wr_rdy_o, rd_rdy_o, rsp_val_o, rsp_dat_o
  );
  modport slave (
    input  wr_val_i, wr_adr_i, wr_dat_i, rd_val_i, rd_adr_i, rsp_rdy_i,
    output wr_rdy_o, rd_rdy_o, rsp_val_o, rsp_dat_o
  );
endinterface

// File: rtl/sram_rsp_fifo.sv
// sram_rsp_fifo: small synchronous FIFO holding read responses
module sram_rsp_fifo #(
  parameter int DEPTH = 2,
  parameter int WD    = 32,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [WD-1:0] din,
  output logic [WD-1:0] dout,
  output logic [CW-1:0] cnt,
  output logic          full,
  output logic          empty
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [WD-1:0] mem_q [DEPTH];
  logic [WD-1:0] mem_d [DEPTH];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // storage and pointers; contents need no reset, only the pointers and count
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
    mem_q <= mem_d;
  end
  // next pointers and occupancy; simultaneous push and pop keep the count
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wp_q] = din;
    wp_d  = push ? (wp_q == PW'(DEPTH - 1) ? '0 : wp_q + PW'(1)) : wp_q;
    rp_d  = pop ? (rp_q == PW'(DEPTH - 1) ? '0 : rp_q + PW'(1)) : rp_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end
  assign dout  = mem_q[rp_q];
  assign cnt   = cnt_q;
  assign full  = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
endmodule

// File: rtl/sram_sp_port_ctrl.sv
// sram_sp_port_ctrl: round-robin write/read merge onto a single-port SRAM with credited responses
module sram_sp_port_ctrl import sram_sp_port_ctrl_pkg::*; #(
  parameter int ADR_WD    = ADR_WD_DEF,
  parameter int DAT_WD    = DAT_WD_DEF,
  parameter int RSP_DEPTH = RSP_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  sram_sp_port_ctrl_if.slave bus,
  output logic [ADR_WD-1:0] ram_adr_o,
  output logic              ram_wr_ena_o,
  output logic [DAT_WD-1:0] ram_wr_dat_o,
  output logic              ram_rd_ena_o,
  input  logic [DAT_WD-1:0] ram_rd_dat_i
);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  gnt_e              gnt, last_q, last_d;
  logic              rd_pend_q, rd_pend_d;
  logic [CW-1:0]     cnt;
  logic [CW:0]       credit;
  logic              full, empty, push, pop, rd_ok, rsp_val;
  logic [DAT_WD-1:0] fifo_dout;
  // grant history and the read currently inside the RAM
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q    <= GNT_RD;
      rd_pend_q <= 1'b0;
    end else begin
      last_q    <= last_d;
      rd_pend_q <= rd_pend_d;
    end
  end
  // arbitration: reads only with a free response slot, ties go to the side not granted last
  always_comb begin
    rsp_val   = !rst && !empty;
    pop       = rsp_val && bus.rsp_rdy_i;
    credit    = {1'b0, cnt} + {{CW{1'b0}}, rd_pend_q} - {{CW{1'b0}}, pop};
    rd_ok     = credit < (CW + 1)'(RSP_DEPTH);
    gnt       = rst ? GNT_IDLE :
                bus.wr_val_i && (!(bus.rd_val_i && rd_ok) || last_q == GNT_RD) ? GNT_WR :
                bus.rd_val_i && rd_ok ? GNT_RD : GNT_IDLE;
    last_d    = gnt == GNT_IDLE ? last_q : gnt;
    rd_pend_d = gnt == GNT_RD;
    push      = rd_pend_q && (!full || pop);
  end
  // handshake and RAM drive follow the grant directly
  always_comb begin
    bus.wr_rdy_o  = gnt == GNT_WR;
    bus.rd_rdy_o  = gnt == GNT_RD;
    bus.rsp_val_o = rsp_val;
    bus.rsp_dat_o = fifo_dout;
    ram_wr_ena_o  = gnt == GNT_WR;
    ram_rd_ena_o  = gnt == GNT_RD;
    ram_adr_o     = gnt == GNT_WR ? bus.wr_adr_i : gnt == GNT_RD ? bus.rd_adr_i : '0;
    ram_wr_dat_o  = gnt == GNT_WR ? bus.wr_dat_i : '0;
  end
  sram_rsp_fifo #(.DEPTH(RSP_DEPTH), .WD(DAT_WD), .CW(CW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (ram_rd_dat_i),
    .dout  (fifo_dout),
    .cnt   (cnt),
    .full  (full),
    .empty (empty)
  );
endmodule

// File: tb/tb_sram_sp_port_ctrl.sv
// tb_sram_sp_port_ctrl: random and directed traffic against a transaction-level model
module tb_sram_sp_port_ctrl;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int DEPTH = 2;
  typedef struct {
    logic [DW-1:0] dat;
    int            cyc;
  } ent_t;
  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] ram_adr;
  logic          ram_wr_ena, ram_rd_ena;
  logic [DW-1:0] ram_wr_dat, ram_rd_dat;
  logic [DW-1:0] ram [1024];
  logic [DW-1:0] ref_mem [1024];
  ent_t          q[$];
  bit            last_rd;
  int            cyc, n_vec, n_err, nw, nr, k;
  logic          obs_wr, obs_rd;
  sram_sp_port_ctrl_if #(.ADR_WD(AW), .DAT_WD(DW)) bus ();
  sram_sp_port_ctrl #(.ADR_WD(AW), .DAT_WD(DW), .RSP_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .ram_adr_o    (ram_adr),
    .ram_wr_ena_o (ram_wr_ena),
    .ram_wr_dat_o (ram_wr_dat),
    .ram_rd_ena_o (ram_rd_ena),
    .ram_rd_dat_i (ram_rd_dat)
  );
  always #5 clk = ~clk;
  // behavioural single-port RAM, one cycle read latency
  always @(posedge clk) begin
    if (ram_wr_ena) ram[ram_adr] <= ram_wr_dat;
    if (ram_rd_ena) ram_rd_dat <= ram[ram_adr];
  end
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask
  task automatic cycle(input logic r, input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic rv, input logic [AW-1:0] ra, input logic rr);
    logic head_ok, pop, rq;
    int   g;
    rst = r;
    bus.wr_val_i = wv;
    bus.wr_adr_i = wa;
    bus.wr_dat_i = wd;
    bus.rd_val_i = rv;
    bus.rd_adr_i = ra;
    bus.rsp_rdy_i = rr;
    @(negedge clk);
    head_ok = 1'b0;
    pop = 1'b0;
    g = 0;
    if (!r) begin
      head_ok = q.size() > 0 && q[0].cyc + 2 <= cyc;
      pop = head_ok && rr;
      rq = rv && (q.size() - int'(pop)) < DEPTH;
      g = (wv && (!rq || last_rd)) ? 1 : rq ? 2 : 0;
    end
    chk("wr_rdy", bus.wr_rdy_o, g == 1);
    chk("rd_rdy", bus.rd_rdy_o, g == 2);
    chk("ram_wr_ena", ram_wr_ena, g == 1);
    chk("ram_rd_ena", ram_rd_ena, g == 2);
    chk("ram_adr", ram_adr, g == 1 ? wa : g == 2 ? ra : '0);
    chk("ram_wr_dat", ram_wr_dat, g == 1 ? wd : '0);
    chk("rsp_val", bus.rsp_val_o, head_ok);
    if (head_ok) chk("rsp_dat", bus.rsp_dat_o, q[0].dat);
    obs_wr = bus.wr_rdy_o;
    obs_rd = bus.rd_rdy_o;
    if (r) begin
      q.delete();
      last_rd = 1'b1;
    end else begin
      if (pop) void'(q.pop_front());
      if (g == 1) ref_mem[wa] = wd;
      if (g == 2) q.push_back('{dat: ref_mem[ra], cyc: cyc});
      if (g != 0) last_rd = g == 2;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
  endtask
  initial begin
    n_vec = 0;
    n_err = 0;
    cyc = 0;
    last_rd = 1'b1;
    rst = 1'b1;
    bus.wr_val_i = 1'b0;
    bus.wr_adr_i = '0;
    bus.wr_dat_i = '0;
    bus.rd_val_i = 1'b0;
    bus.rd_adr_i = '0;
    bus.rsp_rdy_i = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, AW'(i), 32'hFFFF_FFFF, 1'b1, AW'(i), 1'b1);
    cycle(1'b0, 1'b1, 10'h005, 32'h1234_5678, 1'b1, 10'h005, 1'b1);
    chk("tie_first_wr", obs_wr, 1'b1);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 10'h005, 1'b1);
    chk("tie_then_rd", obs_rd, 1'b1);
    idle(3);
    for (int i = 0; i < 1024; i++) cycle(1'b0, 1'b1, AW'(i), DW'($urandom), 1'b0, '0, 1'b1);
    cycle(1'b0, 1'b1, 10'h3FF, 32'hDEAD_BEEF, 1'b0, '0, 1'b1);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 10'h3FF, 1'b0);
    chk("rd3ff_acc", obs_rd, 1'b1);
    cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    chk("rd3ff_lat_val", bus.rsp_val_o, 1'b1);
    chk("rd3ff_lat_dat", bus.rsp_dat_o, 32'hDEAD_BEEF);
    idle(3);
    nw = 0;
    nr = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, AW'($urandom), DW'($urandom), 1'b1, AW'($urandom), 1'b1);
      nw += int'(obs_wr);
      nr += int'(obs_rd);
    end
    chk("alt_wr_cnt", nw, 4);
    chk("alt_rd_cnt", nr, 4);
    idle(3);
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, AW'(i), DW'(i), 1'b0, '0, 1'b1);
    nr = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b0, '0, '0, 1'b1, AW'(i), 1'b1);
      nr += int'(obs_rd);
    end
    chk("b2b_rd_cnt", nr, 16);
    idle(3);
    k = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, '0, '0, 1'b1, AW'(k), 1'b0);
      k += int'(obs_rd);
    end
    chk("bp_accepted", k, 2);
    chk("bp_rdy_low", obs_rd, 1'b0);
    for (int i = 0; i < 20 && k < 5; i++) begin
      cycle(1'b0, 1'b0, '0, '0, 1'b1, AW'(k), 1'b1);
      k += int'(obs_rd);
    end
    chk("bp_rest", k, 5);
    idle(4);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 10'h007, 1'b1);
    chk("rst_rd_acc", obs_rd, 1'b1);
    cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b1);
    idle(4);
    chk("rst_no_rsp", bus.rsp_val_o, 1'b0);
    k = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, '0, '0, 1'b1, AW'(i), 1'b0);
      k += int'(obs_rd);
    end
    chk("rst_fifo_empty", k, 2);
    idle(4);
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 99) == 0, 1'($urandom), AW'($urandom), DW'($urandom),
            1'($urandom), AW'($urandom), $urandom_range(0, 9) < 7);
    idle(4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
